// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Performs a W = 4*NIBBLES bit addition by reusing one external combinational
// 4-bit adder. Each clock processes one nibble, starting with the least
// significant one. The ripple carry is held in a register between nibbles,
// and the wide result is built up one nibble at a time.
//
// Optional feature macro: NIBBLE_SERIAL_SUB_EN
//   When defined, the module gains a `sub` input that is sampled with `start`.
//   With sub=1 the block computes A - B mod 2^W as A + ~B + 1.
//   In that mode cout=1 means no borrow occurred.
//
// Handshake:
//   `start` is sampled only in IDLE or DONE. The edge that samples it is the
//   accepting edge; op_a, op_b, cin (and sub) are latched on that edge.
//   `start` is ignored during RUN. `done` is a one-cycle pulse.
//   `result` and `cout` are valid while done=1 and stay held until the next
//   accept. A start presented in the DONE cycle is accepted back-to-back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             operation request
//   op_a, op_b, cin   operands and carry-in (W, W, 1 bits)
//   sub               subtract select (only with NIBBLE_SERIAL_SUB_EN)
//   busy              high while in RUN
//   done              one-cycle result-valid pulse
//   result, cout      assembled sum and final carry
//   add_a, add_b      to shared adder inputs (4 bits each)
//   add_cin           to shared adder carry-in
//   add_sum           from shared adder sum (4 bits)
//   add_carry         from shared adder carry-out
//   state_dbg         current FSM state encoding (IDLE=0, RUN=1, DONE=2)
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry,
  output logic [1:0]           state_dbg
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic            accept;
  logic            last_nibble;
  logic [IDXW+1:0] bit_base;
  logic [W-1:0]    b_in;
  logic            c_in;

  // Low bit index of the nibble currently being processed.
  assign bit_base    = {idx, 2'b00};
  assign last_nibble = (idx == LAST_IDX);
  assign accept      = start && ((state == IDLE) || (state == DONE));

`ifdef NIBBLE_SERIAL_SUB_EN
  // Subtraction is A + ~B + 1. The cin input is ignored when sub=1.
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub ? 1'b1  : cin;
`else
  assign b_in = op_b;
  assign c_in = cin;
`endif

  // Next-state logic and combinational outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[bit_base +: 4];
        add_b   = b_reg[bit_base +: 4];
        add_cin = carry_reg;
        if (last_nibble) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers. The adder is combinational, so its sum for the
  // current nibble is captured on the same edge that advances idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= op_a;
      b_reg     <= b_in;
      carry_reg <= c_in;
    end else if (state == RUN) begin
      result[bit_base +: 4] <= add_sum;
      carry_reg             <= add_carry;
      if (last_nibble) begin
        cout <= add_carry;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
